sysctrl_wb_arbiter: RTL and testbench
=====================================

// Module: sysctrl_wb_arbiter
// PURPOSE
//   Two-master Wishbone arbiter that shares the single sysctrl_wb slave port.
//   Master 0 is the management CPU bus; master 1 is the housekeeping/debug bus.
//   Grants are round-robin and held for a whole cycle (cyc-locked).
//   A watchdog ends any slave access that gets no ack within TIMEOUT_CYCLES.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles of s_stb_o high with no s_ack_i before the watchdog aborts; legal range >=2
//   TO_W  $clog2(TIMEOUT_CYCLES+1)  width of the watchdog counter (derived)
// PORTS
//   wb_clk_i         in   1   single clock for all logic
//   wb_rst_ni        in   1   asynchronous reset, active low
//   mN_cyc_i/stb_i   in   1   master N cycle/strobe (N=0,1)
//   mN_we_i          in   1   master N write enable
//   mN_sel_i         in   4   master N byte selects
//   mN_adr_i         in   32  master N address
//   mN_dat_i         in   32  master N write data
//   mN_ack_o         out  1   master N ack
//   mN_err_o         out  1   master N error (watchdog abort)
//   mN_dat_o         out  32  master N read data
//   s_cyc_o/s_stb_o  out  1   to sysctrl_wb
//   s_we_o           out  1   to sysctrl_wb
//   s_sel_o          out  4   to sysctrl_wb
//   s_adr_o/s_dat_o  out  32  to sysctrl_wb
//   s_ack_i          in   1   from sysctrl_wb
//   s_dat_i          in   32  from sysctrl_wb
//   grant_o          out  2   one-hot current owner; 2'b00 when idle
//   timeout_o        out  1   1-cycle pulse when the watchdog fires
// BEHAVIOUR
//   - Reset (async, wb_rst_ni=0): state=IDLE; grant_o=0; last=1 (so m0 wins the first tie).
//     All s_* outputs, mN_ack_o, mN_err_o, mN_dat_o and timeout_o are 0. Watchdog counter=0.
//     Reset asserted mid-access drops s_cyc_o immediately and gives no ack.
//   - req[N] = mN_cyc_i & mN_stb_i.
//   - IDLE: at a clock edge, one requester gets the grant. If both request, the one != last wins.
//     Next state is OWN; last is set to the winner. Latency is 1 cycle from req to s_stb_o.
//   - OWN: s_* are combinational copies of the owner's signals.
//     s_cyc_o = owner cyc; s_stb_o = owner stb.
//     s_ack_i routes to the owner's ack (same cycle); s_dat_i routes to the owner's dat_o.
//     The other master sees ack=0, err=0, dat_o=0.
//   - Release: at the edge where owner cyc_i=0, the owner gives up the grant.
//     If the other master requests on that edge, it is granted directly (no idle cycle).
//     Otherwise the next state is IDLE.
//   - Watchdog: the counter increments each cycle with s_stb_o=1 and s_ack_i=0.
//     It clears on s_ack_i or on release.
//     When the count reaches TIMEOUT_CYCLES: next state ERR; owner err_o=1 for one cycle;
//     timeout_o=1 for one cycle; s_cyc_o/s_stb_o forced to 0.
//   - ERR: s_* held at 0 until the owner drops cyc_i, then release as above.
//     An s_ack_i arriving in ERR is ignored.
//   - Simultaneous s_ack_i and timeout on the same cycle: the ack wins; no err.
//   - ack and err are never high together to one master.
// STRUCTURE
//   - Package sysctrl_arb_pkg: state enum {IDLE, OWN, ERR}; master index constants M_CPU=0, M_HK=1.
//   - Sub-module sysctrl_arb_rr: 2-way round-robin pick (req[1:0], last -> winner).
//   - The FSM, watchdog and muxes live in this module.
// TESTING
//   1 m0 writes 32'h1 to CLK_OUT -> s_* mirror m0 one cycle after the request;
//     m0_ack pulses; grant_o=01; readback by m0 returns 32'h1.
//   2 m0 and m1 raise cyc/stb on the same edge after reset -> m0 granted first;
//     when m0 drops cyc, m1 is granted on the same edge (grant_o 01->10).
//   3 Repeated simultaneous requests, 4 transactions -> grants alternate m0,m1,m0,m1.
//   4 Slave stub holds ack low -> after 16 cycles of stb: err to owner, timeout_o pulse,
//     s_cyc_o=0; owner drops cyc -> back to IDLE, counter=0.
//   5 m1 writes 32'h1 to TRAP_OUT, then m0 reads it -> m0_dat_o=32'h1; m1_dat_o stays 0.
//   6 Pull wb_rst_ni low mid-access -> all outputs 0 within the same cycle (async);
//     after release, the first tie goes to m0.

Source files
------------

// File: rtl/sysctrl_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysctrl_arb_pkg : state encoding and master indices for the sysctrl arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package sysctrl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    localparam int M_CPU = 0;
    localparam int M_HK  = 1;

    function automatic logic [1:0] owner_onehot(input logic owner);
        logic [1:0] v;
        v = 2'b00;
        v[owner ? M_HK : M_CPU] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysctrl_arb_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysctrl_arb_rr : two-way round-robin pick; on a tie the master != last wins
// Revision: 1.0
// ---------------------------------------------------------------------------
module sysctrl_arb_rr
    import sysctrl_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = i_req[M_HK];
        if (&i_req) begin
            o_winner = ~i_last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysctrl_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysctrl_wb_arbiter : two-master cyc-locked round-robin Wishbone arbiter
//                      with a no-ack watchdog on the shared slave port
// Revision: 1.0
// ---------------------------------------------------------------------------
module sysctrl_wb_arbiter
    import sysctrl_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] c_cnt_last = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e      r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_last,  w_last_nxt;
    logic [TO_W-1:0] r_cnt,   w_cnt_nxt;
    logic            r_err,   w_err_nxt;
    logic            w_pick;
    logic [1:0]      w_req;
    logic            w_rr_valid;
    logic            w_rr_winner;
    logic            w_own_cyc;
    logic            w_own_stb;

    assign w_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;

    sysctrl_arb_rr u_rr (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_valid  (w_rr_valid),
        .o_winner (w_rr_winner)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Release and idle share one path: the departing owner's req is 0, so
    // the round-robin pick hands over directly to the other master if it waits.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_pick      = 1'b0;
        unique case (r_state)
            IDLE: w_pick = 1'b1;
            OWN: begin
                if (!w_own_cyc) begin
                    w_pick = 1'b1;
                end else if (s_ack_i) begin
                    w_cnt_nxt = '0;
                end else if (w_own_stb) begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ERR: begin
                if (!w_own_cyc) begin
                    w_pick = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_pick) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            if (w_rr_valid) begin
                w_state_nxt = OWN;
                w_owner_nxt = w_rr_winner;
                w_last_nxt  = w_rr_winner;
            end
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'h0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'h0;
        if (r_state == OWN) begin
            s_cyc_o = w_own_cyc;
            s_stb_o = w_own_stb;
            s_we_o  = r_owner ? m1_we_i  : m0_we_i;
            s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
            s_adr_o = r_owner ? m1_adr_i : m0_adr_i;
            s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
            if (r_owner == 1'(M_HK)) begin
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end else begin
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
        end
    end

    // The error pulse is only ever raised in the first ERR cycle, where no ack is routed.
    assign m0_err_o  = r_err & (r_owner == 1'(M_CPU));
    assign m1_err_o  = r_err & (r_owner == 1'(M_HK));
    assign timeout_o = r_err;
    assign grant_o   = (r_state == IDLE) ? 2'b00 : owner_onehot(r_owner);

endmodule
`default_nettype wire

// File: tb/tb_sysctrl_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sysctrl_wb_arbiter : vector table, directed watchdog/reset sequences and
//                         randomized traffic against a transaction-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sysctrl_wb_arbiter;

    localparam int          TO       = 16;
    localparam logic [31:0] CLK_OUT  = 32'h0000_0010;
    localparam logic [31:0] TRAP_OUT = 32'h0000_0020;
    localparam int          NROWS    = 23;
    localparam int          NRAND    = 800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcyc [2];
    logic        mstb [2];
    logic        mwe  [2];
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    logic        slave_en, force_ack, mem_clr;
    logic [31:0] mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sysctrl_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),       .wb_rst_ni(rst_n),
        .m0_cyc_i (mcyc[0]),   .m0_stb_i (mstb[0]),  .m0_we_i (mwe[0]),
        .m0_sel_i (msel[0]),   .m0_adr_i (madr[0]),  .m0_dat_i(mdat[0]),
        .m0_ack_o (m0_ack_o),  .m0_err_o (m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i (mcyc[1]),   .m1_stb_i (mstb[1]),  .m1_we_i (mwe[1]),
        .m1_sel_i (msel[1]),   .m1_adr_i (madr[1]),  .m1_dat_i(mdat[1]),
        .m1_ack_o (m1_ack_o),  .m1_err_o (m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o  (s_cyc_o),   .s_stb_o  (s_stb_o),  .s_we_o  (s_we_o),
        .s_sel_o  (s_sel_o),   .s_adr_o  (s_adr_o),  .s_dat_o (s_dat_o),
        .s_ack_i  (s_ack_i),   .s_dat_i  (s_dat_i),
        .grant_o  (grant_o),   .timeout_o(timeout_o)
    );

    // Register-file slave stub: zero-wait ack when enabled, byte-lane writes.
    assign s_ack_i = force_ack | (slave_en & s_cyc_o & s_stb_o);
    assign s_dat_i = (s_cyc_o & s_stb_o) ? mem[s_adr_o[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
            for (int b = 0; b < 4; b++)
                if (s_sel_o[b]) mem[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [141:0] all_outs();
        return {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
                m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
                grant_o, timeout_o};
    endfunction

    task automatic drive(input int m, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        mcyc[m] = c; mstb[m] = s; mwe[m] = w; msel[m] = 4'hF; madr[m] = a; mdat[m] = d;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic c0, s0, w0; logic [31:0] a0, d0;
        logic c1, s1, w1; logic [31:0] a1, d1;
        logic [1:0] g; logic sc, ss; logic [1:0] ack; logic [31:0] r0, r1;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t row(logic c0, logic s0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                 logic c1, logic s1, logic w1, logic [31:0] a1, logic [31:0] d1,
                                 logic [1:0] g, logic sc, logic ss, logic [1:0] ack,
                                 logic [31:0] r0, logic [31:0] r1);
        vec_t v;
        v = {c0, s0, w0, a0, d0, c1, s1, w1, a1, d1, g, sc, ss, ack, r0, r1};
        return v;
    endfunction

    // ---------------- transaction-level reference model ----------------
    int mo_owner;   // -1: bus free
    int mo_last;
    int mo_wait;
    bit mo_fault;
    bit mo_errp;
    bit mo_ack_in;

    task automatic model_reset();
        mo_owner = -1; mo_last = 1; mo_wait = 0; mo_fault = 0; mo_errp = 0;
    endtask

    function automatic int pick(bit r0, bit r1, int last);
        if (r0 && r1) return 1 - last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        bit r0, r1, nerr;
        int w;
        r0 = mcyc[0] & mstb[0];
        r1 = mcyc[1] & mstb[1];
        nerr = 0;
        if (mo_owner < 0 || !mcyc[mo_owner]) begin
            w = pick(r0, r1, mo_last);
            mo_owner = w;
            if (w >= 0) mo_last = w;
            mo_wait = 0;
            mo_fault = 0;
        end else if (!mo_fault) begin
            if (mo_ack_in) mo_wait = 0;
            else if (mstb[mo_owner]) begin
                mo_wait++;
                if (mo_wait >= TO) begin
                    mo_fault = 1;
                    nerr = 1;
                end
            end
        end
        mo_errp = nerr;
    endtask

    task automatic model_check();
        bit live;
        logic ec, es, ew;
        logic [3:0] esel;
        logic [31:0] ea, ed, esd;
        logic [1:0] eg;
        logic [33:0] er [2];
        ec = 0; es = 0; ew = 0; esel = 0; ea = 0; ed = 0;
        live = (mo_owner >= 0) && !mo_fault;
        if (live) begin
            ec = mcyc[mo_owner]; es = mstb[mo_owner]; ew = mwe[mo_owner];
            esel = msel[mo_owner]; ea = madr[mo_owner]; ed = mdat[mo_owner];
        end
        mo_ack_in = force_ack | (slave_en & ec & es);
        esd = (ec & es) ? mem[ea[5:2]] : 32'h0;
        eg = (mo_owner < 0) ? 2'b00 : ((mo_owner == 0) ? 2'b01 : 2'b10);
        for (int m = 0; m < 2; m++) begin
            er[m] = 34'h0;
            if (mo_owner == m) begin
                er[m][33] = live & mo_ack_in;
                er[m][32] = mo_errp;
                er[m][31:0] = live ? esd : 32'h0;
            end
        end
        chk("rnd_grant", grant_o, eg);
        chk("rnd_sbus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o},
                        {ec, es, ew, esel, ea, ed});
        chk("rnd_m0", {m0_ack_o, m0_err_o, m0_dat_o}, er[0]);
        chk("rnd_m1", {m1_ack_o, m1_err_o, m1_dat_o}, er[1]);
        chk("rnd_timeout", timeout_o, mo_errp);
    endtask

    initial begin
        // A: CLK_OUT, T: TRAP_OUT. Rows 0-9 tie/alternation, 10-15 m0 write/read,
        // 16-21 m1 writes TRAP_OUT then m0 reads it back.
        tbl[0]  = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);
        tbl[1]  = row(1,1,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);
        tbl[2]  = row(1,1,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b01,1,1,2'b01, 0,0);
        tbl[3]  = row(0,0,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b01,0,0,2'b00, 0,0);
        tbl[4]  = row(1,1,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b10,1,1,2'b10, 0,0);
        tbl[5]  = row(1,1,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b10,0,0,2'b00, 0,0);
        tbl[6]  = row(1,1,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b01,1,1,2'b01, 0,0);
        tbl[7]  = row(0,0,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b01,0,0,2'b00, 0,0);
        tbl[8]  = row(1,1,0,CLK_OUT,0, 1,1,0,TRAP_OUT,0, 2'b10,1,1,2'b10, 0,0);
        tbl[9]  = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b10,0,0,2'b00, 0,0);
        tbl[10] = row(1,1,1,CLK_OUT,1, 0,0,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);
        tbl[11] = row(1,1,1,CLK_OUT,1, 0,0,0,TRAP_OUT,0, 2'b01,1,1,2'b01, 0,0);
        tbl[12] = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b01,0,0,2'b00, 0,0);
        tbl[13] = row(1,1,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);
        tbl[14] = row(1,1,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b01,1,1,2'b01, 1,0);
        tbl[15] = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b01,0,0,2'b00, 0,0);
        tbl[16] = row(0,0,0,CLK_OUT,0, 1,1,1,TRAP_OUT,1, 2'b00,0,0,2'b00, 0,0);
        tbl[17] = row(0,0,0,CLK_OUT,0, 1,1,1,TRAP_OUT,1, 2'b10,1,1,2'b10, 0,0);
        tbl[18] = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b10,0,0,2'b00, 0,0);
        tbl[19] = row(1,1,0,TRAP_OUT,0, 0,0,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);
        tbl[20] = row(1,1,0,TRAP_OUT,0, 0,0,0,TRAP_OUT,0, 2'b01,1,1,2'b01, 1,0);
        tbl[21] = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b01,0,0,2'b00, 0,0);
        tbl[22] = row(0,0,0,CLK_OUT,0, 0,0,0,TRAP_OUT,0, 2'b00,0,0,2'b00, 0,0);

        rst_n = 1'b0; mem_clr = 1'b1; slave_en = 1'b1; force_ack = 1'b0;
        for (int m = 0; m < 2; m++) drive(m, 0, 0, 0, 32'h0, 32'h0);
        #2;
        chk("reset_outputs", all_outs(), 142'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; mem_clr = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            drive(0, tbl[i].c0, tbl[i].s0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
            drive(1, tbl[i].c1, tbl[i].s1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("vec_row%0d", i),
                {grant_o, s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o, m0_dat_o, m1_dat_o,
                 m0_err_o, m1_err_o, timeout_o},
                {tbl[i].g, tbl[i].sc, tbl[i].ss, tbl[i].ack, tbl[i].r0, tbl[i].r1, 3'b000});
            next();
        end

        // Watchdog: slave never acks.
        slave_en = 1'b0;
        drive(0, 1, 1, 0, CLK_OUT, 0);
        @(negedge clk);
        chk("wd_idle_grant", grant_o, 2'b00);
        for (int k = 1; k <= TO; k++) begin
            next();
            @(negedge clk);
            chk($sformatf("wd_wait%0d", k), {s_cyc_o, s_stb_o, m0_err_o, timeout_o}, 4'b1100);
        end
        next();
        @(negedge clk);
        chk("wd_fire", {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_err_o, timeout_o},
            {2'b01, 6'b000101});
        next();
        force_ack = 1'b1;
        @(negedge clk);
        chk("wd_err_hold", {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, timeout_o},
            {2'b01, 5'b00000});
        next();
        force_ack = 1'b0;
        drive(0, 0, 0, 0, CLK_OUT, 0);
        @(negedge clk);
        chk("wd_drop_grant", grant_o, 2'b01);
        next();
        @(negedge clk);
        chk("wd_idle_again", grant_o, 2'b00);

        // Ack arriving on the last permitted cycle beats the watchdog.
        drive(0, 1, 1, 0, CLK_OUT, 0);
        next();
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            chk($sformatf("ackwin_wait%0d", k), {s_stb_o, m0_err_o, timeout_o}, 3'b100);
            next();
        end
        slave_en = 1'b1;
        @(negedge clk);
        chk("ackwin_ack", {m0_ack_o, m0_err_o, timeout_o}, 3'b100);
        next();
        slave_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("ackwin_after", {grant_o, s_stb_o, m0_err_o, timeout_o}, 5'b01100);
            next();
        end
        drive(0, 0, 0, 0, CLK_OUT, 0);
        next();

        // Asynchronous reset in the middle of an m0 access.
        slave_en = 1'b1;
        drive(0, 1, 1, 0, CLK_OUT, 0);
        next();
        #2;
        chk("rst_pre_cyc", {grant_o, s_cyc_o, m0_ack_o}, 4'b0111);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", all_outs(), 142'h0);
        drive(1, 1, 1, 0, TRAP_OUT, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        next();
        @(negedge clk);
        chk("rst_first_tie", {grant_o, m0_ack_o, m1_ack_o}, 4'b0110);
        drive(0, 0, 0, 0, CLK_OUT, 0);
        drive(1, 0, 0, 0, TRAP_OUT, 0);
        next();

        // Randomized traffic; the second half makes acks rare and bursts long.
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < NRAND; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m]) begin
                    if ($urandom_range(0, (i < NRAND/2) ? 7 : 40) == 0) begin
                        mcyc[m] = 1'b0; mstb[m] = 1'b0;
                    end else begin
                        mstb[m] = ($urandom_range(0, 3) != 0);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    mcyc[m] = 1'b1; mstb[m] = 1'b1;
                end
                mwe[m]  = 1'($urandom_range(0, 1));
                msel[m] = 4'($urandom_range(0, 15));
                madr[m] = $urandom;
                mdat[m] = $urandom;
            end
            slave_en  = (i < NRAND/2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            force_ack = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
